// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply/divide, one iteration per clock over WIDTH cycles.
// Both ops run on operand magnitudes in a shared 2*WIDTH register; signs are fixed up on completion.
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] prod, step, sprod;
   logic [WIDTH-1:0] opnd, mag_a, mag_b, diff, res;
   logic [WIDTH:0] add_sum, sh;
   logic [WIDTH:0] p_hi;
   logic is_mul, neg, bz, ovf, start, fin, borrow, exc;
   assign start = ctrl_MULT | ctrl_DIV;
   assign fin = cnt == CW'(WIDTH);
   assign busy = state == RUN;
   assign data_resultRDY = state == DONE;
   assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (state == RUN) state_nx = fin ? DONE : RUN;
      else state_nx = start ? RUN : IDLE;
   end
   // multiply: add-and-shift right; divide: restoring shift-subtract, quotient fills the low word
   always_comb begin
      add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? opnd : {WIDTH{1'b0}}};
      sh = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      borrow = sh < {1'b0, opnd};
      diff = sh[WIDTH-1:0] - opnd;
      step = is_mul ? {add_sum, prod[WIDTH-1:1]}
           : borrow ? {sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
           : {diff, prod[WIDTH-2:0], 1'b1};
      sprod = neg ? -prod : prod;
      p_hi = sprod[2*WIDTH-1:WIDTH-1];
      res = (!is_mul && bz) ? {WIDTH{1'b0}} : sprod[WIDTH-1:0];
      exc = is_mul ? !(&p_hi || ~|p_hi) : (bz || ovf);
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         cnt <= '0;
         prod <= '0;
         opnd <= '0;
         is_mul <= 1'b0;
         neg <= 1'b0;
         bz <= 1'b0;
         ovf <= 1'b0;
         data_result <= '0;
         data_exception <= 1'b0;
      end else if (state != RUN && start) begin
         cnt <= '0;
         is_mul <= ctrl_MULT;
         neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         bz <= data_operandB == '0;
         ovf <= data_operandA == INT_MIN && data_operandB == {WIDTH{1'b1}};
         opnd <= ctrl_MULT ? mag_a : mag_b;
         prod <= {{WIDTH{1'b0}}, ctrl_MULT ? mag_b : mag_a};
      end else if (state == RUN) begin
         if (fin) begin
            data_result <= res;
            data_exception <= exc;
         end else begin
            prod <= step;
            cnt <= cnt + 1'b1;
         end
      end
endmodule
